// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the RV32I ALU: decodes OP, OP-IMM, LUI and AUIPC into a registered ALU bundle
// behind a 2-entry skid buffer. Optional operand forwarding is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
`ifdef ALU_ISSUE_FWD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            alu_cin,
  output logic [4:0]      rd,
  output logic            we,
  output logic            illegal
);

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3, OP_SLTU = 5'd4,
    OP_XOR  = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_OR  = 5'd8, OP_AND  = 5'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
`ifdef ALU_ISSUE_FWD_EN
    logic            use1;
    logic [4:0]      rs1_f;
    logic            use2;
    logic [4:0]      rs2_f;
`endif
  } entry_t;

  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic b30, input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && b30) ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = b30 ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                                    input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
    entry_t      e;
    logic [2:0]  f3;
    logic [XLEN-1:0] imm_i, imm_u, shamt;
    f3    = instr[14:12];
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_u = {instr[31:12], 12'b0};
    shamt = {27'b0, instr[24:20]};
    e     = '0;
    e.rd  = instr[11:7];
    case (instr[6:0])
      7'b0110011: begin
        e.op = f3_to_op(f3, instr[30], 1'b1);
        e.a  = rs1;
        e.b  = rs2;
`ifdef ALU_ISSUE_FWD_EN
        e.use1 = 1'b1;
        e.use2 = 1'b1;
`endif
      end
      7'b0010011: begin
        e.op = f3_to_op(f3, instr[30], 1'b0);
        e.a  = rs1;
        e.b  = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
`ifdef ALU_ISSUE_FWD_EN
        e.use1 = 1'b1;
`endif
      end
      7'b0110111: e.b = imm_u;
      7'b0010111: begin
        e.a = pc;
        e.b = imm_u;
      end
      default: e.illegal = 1'b1;
    endcase
`ifdef ALU_ISSUE_FWD_EN
    e.rs1_f = instr[19:15];
    e.rs2_f = instr[24:20];
`endif
    e.we = !e.illegal && (e.rd != 5'd0);
    return e;
  endfunction

  entry_t main_q, skid_q, main_hold, skid_hold, main_n, skid_n, new_e;
  logic   main_v, skid_v, main_v_n, skid_v_n, in_ready_q;
  logic   accept, issue;
  logic [XLEN-1:0] rs1_eff, rs2_eff;

  assign accept = in_valid && in_ready_q;
  assign issue  = main_v && out_ready;

`ifdef ALU_ISSUE_FWD_EN
  logic fwd_hit;
  assign fwd_hit = fwd_valid && (fwd_rd != 5'd0);
  assign rs1_eff = (fwd_hit && fwd_rd == in_instr[19:15]) ? fwd_data : in_rs1;
  assign rs2_eff = (fwd_hit && fwd_rd == in_instr[24:20]) ? fwd_data : in_rs2;

  // Buffered entries keep snooping the forward bus until they issue.
  function automatic entry_t fwd_apply(input entry_t e, input logic hit, input logic [4:0] frd,
                                       input logic [XLEN-1:0] fdata);
    entry_t r;
    r = e;
    if (hit && e.use1 && e.rs1_f == frd) r.a = fdata;
    if (hit && e.use2 && e.rs2_f == frd) r.b = fdata;
    return r;
  endfunction

  assign main_hold = fwd_apply(main_q, fwd_hit, fwd_rd, fwd_data);
  assign skid_hold = fwd_apply(skid_q, fwd_hit, fwd_rd, fwd_data);
`else
  assign rs1_eff   = in_rs1;
  assign rs2_eff   = in_rs2;
  assign main_hold = main_q;
  assign skid_hold = skid_q;
`endif

  assign new_e = decode(in_instr, in_pc, rs1_eff, rs2_eff);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    main_n   = main_hold;
    skid_n   = skid_hold;
    main_v_n = main_v;
    skid_v_n = skid_v;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (!main_v) begin
      if (accept) begin
        main_n   = new_e;
        main_v_n = 1'b1;
      end
    end else if (issue) begin
      if (skid_v) begin
        main_n   = skid_hold;
        skid_v_n = 1'b0;
      end else if (accept) begin
        main_n = new_e;
      end else begin
        main_v_n = 1'b0;
      end
    end else if (accept) begin
      skid_n   = new_e;
      skid_v_n = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: entry payloads are reset too because they drive the data outputs, which must read 0.
      main_q     <= '0;
      skid_q     <= '0;
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      main_v     <= main_v_n;
      skid_v     <= skid_v_n;
      in_ready_q <= !skid_v_n;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign alu_op    = main_q.op;
  assign alu_a     = main_q.a;
  assign alu_b     = main_q.b;
  assign alu_cin   = 1'b0;
  assign rd        = main_q.rd;
  assign we        = main_q.we;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus random traffic against a queue-based
// reference model that decodes from instruction-class tables.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2, alu_a, alu_b;
  logic [4:0]  alu_op, rd;
  logic        alu_cin, we, illegal;
  logic        m_fv;
  logic [4:0]  m_frd;
  logic [31:0] m_fd;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
`ifdef ALU_ISSUE_FWD_EN
    .fwd_valid(m_fv), .fwd_rd(m_frd), .fwd_data(m_fd),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .rd(rd), .we(we), .illegal(illegal)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  // Base op per funct3; SUB and SRA are the base code plus one.
  localparam int BASE_OP [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t m;
    int   f3;
    f3    = int'(ins[14:12]);
    m.op  = 5'd0;
    m.a   = 32'd0;
    m.b   = 32'd0;
    m.rd  = ins[11:7];
    m.ill = 1'b0;
    if (ins[6:0] == 7'h33) begin
      m.op = 5'(BASE_OP[f3] + (((f3 == 0 || f3 == 5) && ins[30]) ? 1 : 0));
      m.a  = r1;
      m.b  = r2;
    end else if (ins[6:0] == 7'h13) begin
      m.op = 5'(BASE_OP[f3] + ((f3 == 5 && ins[30]) ? 1 : 0));
      m.a  = r1;
      m.b  = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
    end else if (ins[6:0] == 7'h37) begin
      m.b = ins & 32'hFFFF_F000;
    end else if (ins[6:0] == 7'h17) begin
      m.a = pc;
      m.b = ins & 32'hFFFF_F000;
    end else begin
      m.ill = 1'b1;
    end
    m.we = !m.ill && (m.rd != 5'd0);
    return m;
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("alu_cin", 32'(alu_cin), 32'd0);
    if (q.size() > 0) begin
      check("alu_op", 32'(alu_op), 32'(q[0].op));
      check("alu_a", alu_a, q[0].a);
      check("alu_b", alu_b, q[0].b);
      check("rd", 32'(rd), 32'(q[0].rd));
      check("we", 32'(we), 32'(q[0].we));
      check("illegal", 32'(illegal), 32'(q[0].ill));
    end
  endtask

  // Called at a negedge: check current outputs, drive one cycle of inputs, advance the model.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input bit ordy, input bit fl);
    bit          acc, iss;
    logic [31:0] r1e, r2e;
    check_outputs();
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    in_rs1    = r1;
    in_rs2    = r2;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2);
    iss = (q.size() > 0) && ordy;
    r1e = (m_fv && m_frd != 0 && m_frd == ins[19:15]) ? m_fd : r1;
    r2e = (m_fv && m_frd != 0 && m_frd == ins[24:20]) ? m_fd : r2;
    if (fl) q.delete();
    else begin
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(model(ins, pc, r1e, r2e));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom();
    case ($urandom_range(0, 5))
      0, 1:    ins[6:0] = 7'h33;
      2, 3:    ins[6:0] = 7'h13;
      4:       ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
      default: ins[6:0] = 7'h03;
    endcase
    return ins;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    m_fv = 1'b0; m_frd = '0; m_fd = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_we", 32'(we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD x3,x1,x2 with rs1=5, rs2=7
    step(1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1, 0);
    check("add_op", 32'(alu_op), 32'd0);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_rd", 32'(rd), 32'd3);
    check("add_we", 32'(we), 32'd1);
    // SRAI x5,x6,4
    step(1, 32'h40435293, 32'h104, 32'h8000_0000, 32'd0, 1, 0);
    check("srai_op", 32'(alu_op), 32'd7);
    check("srai_b", alu_b, 32'd4);
    check("srai_rd", 32'(rd), 32'd5);
    // ADDI x0,x0,0 -> no writeback
    step(1, 32'h00000013, 32'h108, 32'd1, 32'd2, 1, 0);
    check("addi_x0_we", 32'(we), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Three back-to-back with ALU stalled: two accepted, third rejected
    for (int i = 0; i < 3; i++) step(1, rand_instr(), $urandom(), $urandom(), $urandom(), 0, 0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_depth", 32'(q.size()), 32'd2);
    repeat (3) step(0, 0, 0, 0, 0, 1, 0);

    // Flush with both entries full; same-cycle input discarded
    for (int i = 0; i < 2; i++) step(1, rand_instr(), $urandom(), $urandom(), $urandom(), 0, 0);
    step(1, rand_instr(), 0, 0, 0, 1, 1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (2) step(0, 0, 0, 0, 0, 1, 0);

`ifdef ALU_ISSUE_FWD_EN
    m_fv = 1'b1; m_frd = 5'd1; m_fd = 32'h10;
    step(1, 32'h002081B3, 0, 32'd5, 32'd7, 1, 0);
    m_fv = 1'b0;
    check("fwd_a", alu_a, 32'h10);
    m_fv = 1'b1; m_frd = 5'd0; m_fd = 32'h10;
    step(1, 32'h002001B3, 0, 32'd5, 32'd7, 1, 0);
    m_fv = 1'b0;
    check("fwd_x0_a", alu_a, 32'd5);
    step(0, 0, 0, 0, 0, 1, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom(), $urandom(), $urandom(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);

    // Asynchronous reset with both entries full
    for (int i = 0; i < 3; i++) step(1, 32'h002081B3, 0, 32'd9, 32'd9, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_alu_a", alu_a, 32'd0);
    check("arst_rd", 32'(rd), 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++)
      step($urandom_range(0, 1) != 0, rand_instr(), $urandom(), $urandom(), $urandom(), 1, 0);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
